// File: rtl/bank_ram_burst_seq_if.sv
// Sequencer-side bundle: descriptor, slot command/data, upstream write stream, read stream, status.
// Optional desc_stride field exists only when BANK_SEQ_STRIDE_EN is defined.
interface bank_ram_burst_seq_if #(
  parameter int NUM_BANKS  = 5,
  parameter int DATA_WIDTH = 32
);
  localparam int RW = NUM_BANKS * DATA_WIDTH;

  logic                 desc_valid;
  logic                 desc_ready;
  logic                 desc_rw;
  logic [NUM_BANKS-1:0] desc_mask;
  logic [8:0]           desc_base;
  logic [8:0]           desc_len;
`ifdef BANK_SEQ_STRIDE_EN
  logic [8:0]           desc_stride;
`endif

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_rw;
  logic [NUM_BANKS-1:0] cmd_mask;
  logic [8:0]           cmd_addr;

  logic                 wd_in_valid;
  logic                 wd_in_ready;
  logic [RW-1:0]        wd_in_data;

  logic                 wvalid;
  logic [RW-1:0]        wdata;
  logic                 wready;

  logic                 rvalid;
  logic [RW-1:0]        rdata;

  logic                 rd_out_valid;
  logic [RW-1:0]        rd_out_data;

  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    input  desc_valid, desc_rw, desc_mask, desc_base, desc_len,
`ifdef BANK_SEQ_STRIDE_EN
    input  desc_stride,
`endif
    output desc_ready,
    output cmd_valid, cmd_rw, cmd_mask, cmd_addr,
    input  cmd_ready,
    input  wd_in_valid, wd_in_data,
    output wd_in_ready,
    output wvalid, wdata,
    input  wready,
    input  rvalid, rdata,
    output rd_out_valid, rd_out_data,
    output busy, done, err
  );

  modport slave (
    output desc_valid, desc_rw, desc_mask, desc_base, desc_len,
`ifdef BANK_SEQ_STRIDE_EN
    output desc_stride,
`endif
    input  desc_ready,
    input  cmd_valid, cmd_rw, cmd_mask, cmd_addr,
    output cmd_ready,
    output wd_in_valid, wd_in_data,
    input  wd_in_ready,
    input  wvalid, wdata,
    output wready,
    output rvalid, rdata,
    input  rd_out_valid, rd_out_data,
    input  busy, done, err
  );
endinterface

// File: rtl/bank_ram_burst_seq.sv
// Burst sequencer: descriptor -> per-row slot commands (read credits capped at MAX_OUTST), write data passes
// through combinationally, read data registered (1 cycle). BANK_SEQ_STRIDE_EN adds a per-descriptor address stride.
module bank_ram_burst_seq #(
  parameter int NUM_BANKS  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  bank_ram_burst_seq_if.master bus
);
  localparam int         RW    = NUM_BANKS * DATA_WIDTH;
  localparam logic [3:0] MAX_O = 4'(MAX_OUTST);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic                 rw_q, rw_d;
  logic [NUM_BANKS-1:0] mask_q, mask_d;
  logic [8:0]           len_q, len_d;
  logic [8:0]           addr_q, addr_d;
  logic [9:0]           issue_cnt_q, issue_cnt_d;
  logic [9:0]           data_cnt_q, data_cnt_d;
  logic [3:0]           outst_q, outst_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 done_q, done_d;
  logic                 rd_out_valid_q, rd_out_valid_d;
  logic [RW-1:0]        rd_out_data_q, rd_out_data_d;
  logic                 err_q, err_d;
`ifdef BANK_SEQ_STRIDE_EN
  logic [8:0]           stride_q, stride_d;
`endif

  logic       busy;
  logic       wr_qual;
  logic       cmd_hs;
  logic       rd_hs;
  logic       rd_ret;
  logic       wr_beat;
  logic [9:0] beats;
  logic [8:0] step;

`ifdef BANK_SEQ_STRIDE_EN
  assign step = stride_q;
`else
  assign step = 9'd1;
`endif

  assign busy    = (state_q != S_IDLE);
  assign beats   = {1'b0, len_q} + 10'd1;
  assign wr_qual = rw_q && busy && (data_cnt_q <= {1'b0, len_q});
  assign cmd_hs  = cmd_valid_q && bus.cmd_ready;
  assign rd_hs   = cmd_hs && !rw_q;
  // A return only counts against a live credit; anything else is a protocol error.
  assign rd_ret  = bus.rvalid && (outst_q != 4'd0);
  assign wr_beat = bus.wvalid && bus.wready;

  assign bus.desc_ready   = (state_q == S_IDLE);
  assign bus.busy         = busy;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.cmd_valid    = cmd_valid_q;
  assign bus.cmd_rw       = rw_q;
  assign bus.cmd_mask     = mask_q;
  assign bus.cmd_addr     = addr_q;
  assign bus.wvalid       = bus.wd_in_valid && wr_qual;
  assign bus.wd_in_ready  = bus.wready && wr_qual;
  assign bus.wdata        = bus.wd_in_data;
  assign bus.rd_out_valid = rd_out_valid_q;
  assign bus.rd_out_data  = rd_out_data_q;

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    mask_d      = mask_q;
    len_d       = len_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
`ifdef BANK_SEQ_STRIDE_EN
    stride_d    = stride_q;
`endif
    data_cnt_d  = data_cnt_q + ((wr_beat || rd_ret) ? 10'd1 : 10'd0);
    outst_d     = outst_q + (rd_hs ? 4'd1 : 4'd0) - (rd_ret ? 4'd1 : 4'd0);

    case (state_q)
      S_IDLE: begin
        if (bus.desc_valid) begin
          rw_d        = bus.desc_rw;
          mask_d      = bus.desc_mask;
          len_d       = bus.desc_len;
          addr_d      = bus.desc_base;
`ifdef BANK_SEQ_STRIDE_EN
          stride_d    = bus.desc_stride;
`endif
          issue_cnt_d = 10'd0;
          data_cnt_d  = 10'd0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_hs) begin
          issue_cnt_d = issue_cnt_q + 10'd1;
          addr_d      = addr_q + step;
          if (issue_cnt_q == {1'b0, len_q}) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (data_cnt_q == beats) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered from next-state values so cmd_valid matches the current credit count each cycle.
    cmd_valid_d    = (state_d == S_ISSUE) && !(!rw_d && (outst_d == MAX_O));
    done_d         = (state_d == S_DONE);
    rd_out_valid_d = rd_ret;
    rd_out_data_d  = rd_ret ? bus.rdata : rd_out_data_q;
    err_d          = err_q | (bus.rvalid && (outst_q == 4'd0));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      rw_q           <= 1'b0;
      mask_q         <= '0;
      len_q          <= '0;
      addr_q         <= '0;
      issue_cnt_q    <= '0;
      data_cnt_q     <= '0;
      outst_q        <= '0;
      cmd_valid_q    <= 1'b0;
      done_q         <= 1'b0;
      rd_out_valid_q <= 1'b0;
      rd_out_data_q  <= '0;
      err_q          <= 1'b0;
`ifdef BANK_SEQ_STRIDE_EN
      stride_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      rw_q           <= rw_d;
      mask_q         <= mask_d;
      len_q          <= len_d;
      addr_q         <= addr_d;
      issue_cnt_q    <= issue_cnt_d;
      data_cnt_q     <= data_cnt_d;
      outst_q        <= outst_d;
      cmd_valid_q    <= cmd_valid_d;
      done_q         <= done_d;
      rd_out_valid_q <= rd_out_valid_d;
      rd_out_data_q  <= rd_out_data_d;
      err_q          <= err_d;
`ifdef BANK_SEQ_STRIDE_EN
      stride_q       <= stride_d;
`endif
    end
  end
endmodule

// File: tb/tb_bank_ram_burst_seq.sv
// Directed + randomized bursts against a transaction-level model: expected address list, write/read beat queues,
// and a slot that returns reads in order after a random delay.
module tb_bank_ram_burst_seq;
  localparam int NB   = 5;
  localparam int DW   = 32;
  localparam int RW   = NB * DW;
  localparam int MAXO = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bank_ram_burst_seq_if #(.NUM_BANKS(NB), .DATA_WIDTH(DW)) sif ();
  bank_ram_burst_seq #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .MAX_OUTST(MAXO)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (sif)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  int p_cmd, p_wr, p_wd, dly_min, dly_max, wstall;
  bit tog_cmd;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int k = 0; k < NB; k++) r[k*DW +: DW] = $urandom;
    return r;
  endfunction

  task automatic idle_inputs();
    sif.desc_valid  = 1'b0;
    sif.cmd_ready   = 1'b0;
    sif.wready      = 1'b0;
    sif.wd_in_valid = 1'b0;
    sif.rvalid      = 1'b0;
  endtask

  task automatic run_burst(input bit rw, input logic [4:0] mask, input logic [8:0] base,
                           input logic [8:0] len, input logic [8:0] stride);
    logic [8:0]    exp_addr[$];
    logic [RW-1:0] wq[$];
    int            ret_at[$];
    int            ci = 0, wi = 0, rb = 0, outst = 0, cyc = 0, last_ret = -1, wait_n = 0, ret;
    int            nbeat = int'(len) + 1;
    bit            done_ok = 0, exp_rov = 0, stalled = 0, comp = 0, hs;
    logic [8:0]    st_addr = '0;
    logic [RW-1:0] exp_rod = '0;

    for (int i = 0; i < nbeat; i++) begin
      exp_addr.push_back(9'((int'(base) + i * int'(stride)) % 512));
      wq.push_back(rand_row());
    end

    @(negedge clk);
    chk("desc_ready_idle", sif.desc_ready, 1);
    sif.desc_valid = 1'b1;
    sif.desc_rw    = rw;
    sif.desc_mask  = mask;
    sif.desc_base  = base;
    sif.desc_len   = len;
`ifdef BANK_SEQ_STRIDE_EN
    sif.desc_stride = stride;
`endif
    @(posedge clk);

    while (cyc < 3000) begin
      @(negedge clk);
      if (comp) wait_n++;
      chk("rd_out_valid", sif.rd_out_valid, exp_rov);
      if (exp_rov) chk("rd_out_data", sif.rd_out_data, exp_rod);
      chk("done_timing", sif.done, (wait_n == 2));
      chk("busy_in_burst", sif.busy, 1);
      chk("desc_ready_in_burst", sif.desc_ready, 0);
      chk("err_clean", sif.err, 0);
      if (!rw) chk("outst", dut.outst_q, outst);
      if (wait_n == 2) begin
        done_ok = 1;
        chk("cmd_count", ci, nbeat);
        chk("beat_count", rw ? wi : rb, nbeat);
        break;
      end

      // Descriptor lines are noise while busy: the sequencer must ignore them.
      sif.desc_valid  = 1'($urandom_range(1, 0));
      sif.cmd_ready   = tog_cmd ? cyc[0] : ($urandom_range(99, 0) < p_cmd);
      sif.wready      = (cyc < wstall) ? 1'b0 : ($urandom_range(99, 0) < p_wr);
      sif.wd_in_valid = ($urandom_range(99, 0) < p_wd);
      sif.wd_in_data  = (wi < nbeat) ? wq[wi] : rand_row();
      sif.rvalid      = (ret_at.size() > 0) && (ret_at[0] == cyc);
      sif.rdata       = rand_row();
      #1;

      chk("cmd_valid", sif.cmd_valid, (ci < nbeat) && !(!rw && outst == MAXO));
      if (stalled && sif.cmd_valid) chk("cmd_addr_stable", sif.cmd_addr, st_addr);
      if (sif.cmd_valid && ci < nbeat) begin
        chk("cmd_addr", sif.cmd_addr, exp_addr[ci]);
        chk("cmd_rw", sif.cmd_rw, rw);
        chk("cmd_mask", sif.cmd_mask, mask);
      end
      hs      = sif.cmd_valid && sif.cmd_ready;
      stalled = sif.cmd_valid && !sif.cmd_ready;
      st_addr = sif.cmd_addr;

      chk("wvalid", sif.wvalid, sif.wd_in_valid && rw && (wi < nbeat));
      chk("wd_in_ready", sif.wd_in_ready, sif.wready && rw && (wi < nbeat));
      if (sif.wvalid && sif.wready && wi < nbeat) begin
        chk("wdata", sif.wdata, wq[wi]);
        wi++;
      end

      exp_rov = sif.rvalid;
      if (sif.rvalid) begin
        exp_rod = sif.rdata;
        void'(ret_at.pop_front());
        outst--;
        rb++;
      end
      if (hs && ci < nbeat) begin
        ci++;
        if (!rw) begin
          outst++;
          ret = cyc + $urandom_range(dly_max, dly_min);
          if (ret <= last_ret) ret = last_ret + 1;
          ret_at.push_back(ret);
          last_ret = ret;
        end
      end
      comp = comp || ((ci == nbeat) && ((rw ? wi : rb) == nbeat));
      cyc++;
    end
    chk("burst_finished", done_ok, 1);

    idle_inputs();
    @(negedge clk);
    chk("done_after", sif.done, 0);
    chk("busy_after", sif.busy, 0);
    chk("desc_ready_after", sif.desc_ready, 1);
    chk("rd_out_valid_after", sif.rd_out_valid, 0);
  endtask

  initial begin
    logic [8:0] s;
    idle_inputs();
    sif.desc_rw    = 1'b0;
    sif.desc_mask  = '0;
    sif.desc_base  = '0;
    sif.desc_len   = '0;
`ifdef BANK_SEQ_STRIDE_EN
    sif.desc_stride = '0;
`endif
    sif.wd_in_data = '0;
    sif.rdata      = '0;

    repeat (2) @(negedge clk);
    chk("rst_desc_ready", sif.desc_ready, 1);
    chk("rst_busy", sif.busy, 0);
    chk("rst_cmd_valid", sif.cmd_valid, 0);
    chk("rst_rd_out_valid", sif.rd_out_valid, 0);
    chk("rst_done", sif.done, 0);
    chk("rst_err", sif.err, 0);
    rstn = 1'b1;

    p_cmd = 100; p_wr = 100; p_wd = 100; dly_min = 3; dly_max = 3; tog_cmd = 0; wstall = 0;
    run_burst(1'b1, 5'h1F, 9'h010, 9'd3, 9'd1);
    run_burst(1'b0, 5'h1F, 9'h040, 9'd7, 9'd1);
    run_burst(1'b0, 5'h0A, 9'h1FE, 9'd3, 9'd1);
    run_burst(1'b0, 5'h01, 9'h0AA, 9'd0, 9'd1);
    run_burst(1'b1, 5'h02, 9'h0AB, 9'd0, 9'd1);

    tog_cmd = 1; wstall = 5; p_wd = 70;
    run_burst(1'b1, 5'h15, 9'h100, 9'd6, 9'd1);
    run_burst(1'b0, 5'h0F, 9'h180, 9'd9, 9'd1);
    tog_cmd = 0; wstall = 0;

    p_cmd = 80; dly_min = 4; dly_max = 9;
    run_burst(1'b0, 5'h1B, 9'h033, 9'd40, 9'd1);

`ifdef BANK_SEQ_STRIDE_EN
    p_cmd = 100; dly_min = 3; dly_max = 3; p_wd = 100;
    run_burst(1'b0, 5'h1F, 9'h1F8, 9'd2, 9'd4);
    run_burst(1'b1, 5'h11, 9'h077, 9'd3, 9'd0);
`endif

    for (int b = 0; b < 14; b++) begin
      p_cmd = $urandom_range(100, 30);
      p_wr = $urandom_range(100, 30);
      p_wd = $urandom_range(100, 30);
      dly_min = 1;
      dly_max = $urandom_range(8, 1);
      wstall = $urandom_range(3, 0);
`ifdef BANK_SEQ_STRIDE_EN
      s = 9'($urandom);
`else
      s = 9'd1;
`endif
      run_burst(1'($urandom_range(1, 0)), 5'($urandom), 9'($urandom), 9'($urandom_range(24, 0)), s);
    end

    // Stray read return with no credit outstanding.
    @(negedge clk);
    sif.rvalid = 1'b1;
    sif.rdata  = rand_row();
    @(negedge clk);
    sif.rvalid = 1'b0;
    chk("stray_err", sif.err, 1);
    chk("stray_no_rd_out", sif.rd_out_valid, 0);
    chk("stray_desc_ready", sif.desc_ready, 1);
    @(negedge clk);
    chk("stray_err_sticky", sif.err, 1);

    // Reset in the middle of a read burst.
    sif.desc_valid = 1'b1;
    sif.desc_rw    = 1'b0;
    sif.desc_mask  = 5'h1F;
    sif.desc_base  = 9'h123;
    sif.desc_len   = 9'd20;
`ifdef BANK_SEQ_STRIDE_EN
    sif.desc_stride = 9'd1;
`endif
    sif.cmd_ready  = 1'b1;
    @(negedge clk);
    sif.desc_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", sif.busy, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_desc_ready", sif.desc_ready, 1);
    chk("mid_rst_busy", sif.busy, 0);
    chk("mid_rst_cmd_valid", sif.cmd_valid, 0);
    chk("mid_rst_err", sif.err, 0);
    chk("mid_rst_done", sif.done, 0);
    @(negedge clk);
    rstn = 1'b1;
    sif.cmd_ready = 1'b0;
    sif.rvalid    = 1'b1;
    sif.rdata     = rand_row();
    @(negedge clk);
    sif.rvalid = 1'b0;
    chk("late_rvalid_err", sif.err, 1);
    chk("late_rvalid_no_rd_out", sif.rd_out_valid, 0);
    chk("late_rvalid_desc_ready", sif.desc_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
